// File: rtl/sine_wg_seq.sv
// -----------------------------------------------------------------------------
// SineWgSeq : per-channel phase-step sequencer feeding the CORDIC sine
// generator.
//
// Every channel owns one signed angle increment (S2.(RW-3) radians) and one
// pending phase-reset flag. On each sample-rate tick the sequencer walks the
// channels in order, channel 0 first. It presents one increment per channel
// over a valid/ready handshake, with no bubble between channels.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   cfg_d        signed angle step to store (saturated to +/-PI)
//   cfg_ch       channel being configured (out-of-range writes are ignored)
//   cfg_zero     request a phase reset on that channel's next issue
//   cfg_dv       configuration write strobe, always accepted
//   tick         one-clock sample-rate strobe that starts a frame
//   m_sine_d     angle step presented to the generator
//   m_sine_zero  phase-zero flag presented to the generator
//   m_sine_ch    channel number of the presented step
//   m_sine_dv    presented data valid
//   m_sine_dr    generator ready
//   busy         a frame is in progress
//   overrun      one-clock pulse: a tick arrived while a frame was in progress
// -----------------------------------------------------------------------------
module sine_wg_seq #(
    parameter int NR_CHANNELS    = 2,
    parameter int RADIAN_WIDTH   = 28,
    localparam int CHANNEL_WIDTH = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RADIAN_WIDTH-1:0]  cfg_d,
    input  logic [CHANNEL_WIDTH-1:0] cfg_ch,
    input  logic                     cfg_zero,
    input  logic                     cfg_dv,
    input  logic                     tick,
    output logic [RADIAN_WIDTH-1:0]  m_sine_d,
    output logic                     m_sine_zero,
    output logic [CHANNEL_WIDTH-1:0] m_sine_ch,
    output logic                     m_sine_dv,
    input  logic                     m_sine_dr,
    output logic                     busy,
    output logic                     overrun
);

    // PI in the S2.(RW-3) format is twice the rounded half-PI. This keeps PI
    // an even number, exactly as the downstream generator expects it.
    localparam longint HALF_PI = longint'((2.0 ** (RADIAN_WIDTH - 3)) * 3.14159265358979323846 / 2.0);
    localparam logic signed [RADIAN_WIDTH-1:0] PI_STEP = RADIAN_WIDTH'(2 * HALF_PI);
    localparam logic [CHANNEL_WIDTH-1:0] LAST_CH = CHANNEL_WIDTH'(NR_CHANNELS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                     state_q, state_d;
    logic [CHANNEL_WIDTH-1:0]   ch_q, ch_d;
    logic [RADIAN_WIDTH-1:0]    outD_q, outD_d;
    logic                       outZero_q, outZero_d;
    logic [RADIAN_WIDTH-1:0]    step_q [NR_CHANNELS];
    logic [RADIAN_WIDTH-1:0]    step_d [NR_CHANNELS];
    logic [NR_CHANNELS-1:0]     zeroPend_q, zeroPend_d;
    logic [RADIAN_WIDTH-1:0]    satD;
    logic [CHANNEL_WIDTH-1:0]   nextCh;

    // The incoming configuration step is clamped to [-PI, +PI]. The generator
    // treats larger magnitudes as wrapped angles, so storing them would alias.
    always_comb begin
        satD = cfg_d;
        if ($signed(cfg_d) > PI_STEP) begin
            satD = PI_STEP;
        end else if ($signed(cfg_d) < -PI_STEP) begin
            satD = -PI_STEP;
        end
    end

    assign nextCh = ch_q + CHANNEL_WIDTH'(1);

    // Next-state logic for the frame sequencer and the per-channel tables.
    // The loaded outputs always read the *registered* tables. A configuration
    // write in the same cycle therefore only shows up in the next frame.
    // The configuration write is applied last, so a cfg_zero request beats
    // the handshake clear of the same channel.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        outD_d     = outD_q;
        outZero_d  = outZero_q;
        step_d     = step_q;
        zeroPend_d = zeroPend_q;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d   = SEND;
                    ch_d      = '0;
                    outD_d    = step_q[0];
                    outZero_d = zeroPend_q[0];
                end
            end
            SEND: begin
                if (m_sine_dr) begin
                    zeroPend_d[ch_q] = 1'b0;
                    if (ch_q == LAST_CH) begin
                        state_d = IDLE;
                    end else begin
                        ch_d      = nextCh;
                        outD_d    = step_q[nextCh];
                        outZero_d = zeroPend_q[nextCh];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < NR_CHANNELS; i++) begin
            if (cfg_dv && (cfg_ch == CHANNEL_WIDTH'(i))) begin
                step_d[i] = satD;
                if (cfg_zero) begin
                    zeroPend_d[i] = 1'b1;
                end
            end
        end
    end

    // State and table registers. Reset arms every channel's phase-zero flag,
    // so the first frame after reset starts all generators at phase 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            outD_q     <= '0;
            outZero_q  <= 1'b0;
            zeroPend_q <= '1;
            for (int i = 0; i < NR_CHANNELS; i++) begin
                step_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            outD_q     <= outD_d;
            outZero_q  <= outZero_d;
            zeroPend_q <= zeroPend_d;
            for (int i = 0; i < NR_CHANNELS; i++) begin
                step_q[i] <= step_d[i];
            end
        end
    end

    // Valid is simply "frame in progress". A tick that lands during a frame
    // is dropped and flagged in that same cycle.
    assign busy        = (state_q == SEND);
    assign m_sine_dv   = busy;
    assign overrun     = tick && busy;
    assign m_sine_d    = outD_q;
    assign m_sine_zero = outZero_q;
    assign m_sine_ch   = ch_q;

endmodule
